usb_tx_encoder: RTL
===================

Name: usb_tx_encoder

Overview:
Transmit-side line encoder for the USB full-speed link; the counterpart of the receive-path NRZI decoder.
- Accepts packet bytes over a valid/ready handshake and prepends SYNC.
- Serialises LSB-first, applies bit stuffing and NRZI, then terminates with EOP.
- Sits between the packet/protocol controller and the D+/D- pad drivers. Bit timing comes from the shared clk_trans bit-time strobe.

Parameters:
STUFF_LEN, 6, consecutive raw 1s that force one stuffed 0
EOP_SE0_BITS, 2, bit times of SE0 in EOP
SYNC_BYTE, 8'h80, sync pattern, sent LSB-first

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
clk_trans  in  1  one-clk-wide bit-time strobe; all line activity advances only on clk edges where clk_trans=1
tx_data  in  8  packet byte; first byte of a packet is the PID
tx_valid  in  1  tx_data valid
tx_last  in  1  qualifies tx_data as the final byte of the packet
tx_ready  out  1  byte accepted on this clk edge when tx_ready & tx_valid
tx_busy  out  1  packet in progress (any state except IDLE)
tx_underrun  out  1  one-clk pulse: byte needed but tx_valid low
d_plus  out  1  registered line D+
d_minus  out  1  registered line D-

Behaviour:
- Reset (async, any state): state=IDLE; d_plus=1, d_minus=0 (J); tx_busy=0; tx_underrun=0; ones_cnt=0.
- tx_ready is combinational.
- Line encoding:
  - NRZI on the raw stream: raw 0 toggles J/K; raw 1 holds the previous level.
  - J = (1,0); K = (0,1); SE0 = (0,0).
- Bit stuffing:
  - ones_cnt counts consecutive raw 1s across SYNC, DATA and CRC; any 0, including a stuffed 0, clears it.
  - When ones_cnt reaches STUFF_LEN, the next bit time emits a stuffed 0 and the shift register does not advance.
  - A stuff that is pending after the final data/CRC bit is emitted before EOP.
- State machine; transitions only on clk edges with clk_trans=1:
  - IDLE: drive J. If tx_valid=1, go to SYNC and drive SYNC bit0 on that same edge; the byte is NOT consumed yet.
  - SYNC: 8 bit times of SYNC_BYTE. At the last SYNC bit, tx_ready = clk_trans & no stuff pending; the PID loads, then go to DATA.
  - DATA: 8 bit times per byte.
    - At bit 7, if the current byte was not last: tx_ready asserts (same rule as SYNC) and the next byte loads.
    - If the current byte was last: go to CRC (when enabled) or EOP_SE0.
    - If a byte is needed and tx_valid=0: pulse tx_underrun and go to EOP_SE0 (packet truncated).
  - EOP_SE0: SE0 for EOP_SE0_BITS bit times; ones_cnt cleared.
  - EOP_J: J for 1 bit time, then IDLE. tx_busy drops on entering IDLE.
- tx_valid in IDLE arriving on a non-strobe cycle waits for the next strobe.
- No byte is consumed outside the tx_ready window.
- Latency: first line change on the first strobe edge with tx_valid=1 in IDLE.

Optional Feature:
USB_TX_CRC16_EN
- Defined:
  - CRC16 runs over all data bytes except the first (the PID).
  - Polynomial x^16+x^15+x^2+1, init 16'hFFFF.
  - After the last byte, a CRC state sends the complemented remainder, 16 bits LSB-first, stuffed, then EOP_SE0.
  - Single-byte packets (PID only) send no CRC.
- Undefined: the CRC state and logic are absent; DATA goes directly to EOP_SE0.

Decomposition:
- Package usb_pkg: line-state typedef (J/K/SE0 encodings), tx FSM state enum, SYNC/CRC16 polynomial/init constants.
- Sub-module usb_crc16: serial CRC with clear, enable and bit inputs; instantiated only under USB_TX_CRC16_EN.

Test Plan:
- Idle after reset: no tx_valid for 50 strobes -> d_plus/d_minus constant (1,0), tx_busy=0.
- Single byte 8'hC3 with tx_last=1, CRC off:
  - SYNC line sequence is K J K J K J K K.
  - Then 8 PID bit times, then SE0 SE0 J.
  - tx_busy high for 19 strobes.
- Single byte 8'hFF with tx_last=1:
  - After SYNC (ends K): K K K K K (ones_cnt hits 6, including SYNC bit7), stuffed J, then J J J.
  - Then SE0 SE0 J: 20 strobes total.
- Underrun: PID 8'h69 tx_last=0, tx_valid dropped before the next byte window -> tx_underrun pulse once, SE0 SE0 J follows the PID immediately.
- Reset mid-DATA: rst asserted between strobes -> same clk period shows J, tx_busy=0; next tx_valid restarts with SYNC.
- CRC on: bytes 8'hC3, 8'h00, 8'h01 (last) -> CRC bits equal ~crc16(8'h00, 8'h01) LSB-first, with correct stuffing, then EOP.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmit path: line states, FSM
// state codes, SYNC pattern and CRC16 constants.
package usb_pkg;

  // {d_plus, d_minus}
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_CRC     = 3'd3;
  localparam logic [2:0] ST_EOP_SE0 = 3'd4;
  localparam logic [2:0] ST_EOP_J   = 3'd5;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Raw 0 toggles J/K, raw 1 holds the level.
  function automatic line_t nrzi_next(input line_t cur, input logic raw);
    return raw ? cur : ((cur == LINE_J) ? LINE_K : LINE_J);
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 in shift-right form, so the remainder leaves LSB-first.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

  logic [15:0] crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC16_INIT;
    end else if (clr_i) begin
      crc_q <= CRC16_INIT;
    end else if (en_i) begin
      crc_q <= (crc_q >> 1) ^ ((crc_q[0] ^ bit_i) ? POLY_REFL : 16'h0000);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first serialisation, bit stuffing,
// NRZI and EOP. Optional CRC16 trailer under macro USB_TX_CRC16_EN.
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_trans,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d, cnt_nxt;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic [OW-1:0] ones_q, ones_d;
  line_t         line_q, line_d;
  logic          underrun_q, underrun_d;
  logic          stuff_pending, byte_end, emit, emit_bit, to_eop;
`ifdef USB_TX_CRC16_EN
  logic          pid_q, pid_d, crc_en, crc_clr;
  logic [15:0]   crc;
`endif

  assign stuff_pending = (ones_q == OW'(STUFF_LEN));
  assign byte_end      = (cnt_q == 4'd7);
  assign cnt_nxt       = cnt_q + 4'd1;
  // A pending stuffed bit occupies the bit time, so the next byte waits one.
  assign tx_ready = clk_trans && byte_end && !stuff_pending &&
                    ((state_q == ST_SYNC) || ((state_q == ST_DATA) && !last_q));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    last_d     = last_q;
    ones_d     = ones_q;
    line_d     = line_q;
    underrun_d = 1'b0;
    emit       = 1'b0;
    emit_bit   = 1'b0;
    to_eop     = 1'b0;
`ifdef USB_TX_CRC16_EN
    pid_d      = pid_q;
    crc_en     = 1'b0;
`endif
    if (clk_trans) begin
      case (state_q)
        ST_IDLE: begin
          line_d = LINE_J;
          if (tx_valid) begin
            state_d  = ST_SYNC;
            cnt_d    = '0;
            emit     = 1'b1;
            emit_bit = SYNC_BYTE[0];
          end
        end
        ST_SYNC, ST_DATA: begin
          if (stuff_pending) begin
            emit = 1'b1;
          end else if (!byte_end) begin
            cnt_d    = cnt_nxt;
            emit     = 1'b1;
            emit_bit = (state_q == ST_SYNC) ? SYNC_BYTE[cnt_nxt[2:0]] : byte_q[cnt_nxt[2:0]];
`ifdef USB_TX_CRC16_EN
            crc_en   = (state_q == ST_DATA) && !pid_q;
`endif
          end else if ((state_q == ST_DATA) && last_q) begin
`ifdef USB_TX_CRC16_EN
            if (!pid_q) begin
              state_d  = ST_CRC;
              cnt_d    = '0;
              emit     = 1'b1;
              emit_bit = ~crc[0];
            end else begin
              to_eop = 1'b1;
            end
`else
            to_eop = 1'b1;
`endif
          end else if (tx_valid) begin
            state_d  = ST_DATA;
            cnt_d    = '0;
            byte_d   = tx_data;
            last_d   = tx_last;
            emit     = 1'b1;
            emit_bit = tx_data[0];
`ifdef USB_TX_CRC16_EN
            pid_d    = (state_q == ST_SYNC);
            crc_en   = (state_q == ST_DATA);
`endif
          end else begin
            underrun_d = 1'b1;
            to_eop     = 1'b1;
          end
        end
`ifdef USB_TX_CRC16_EN
        ST_CRC: begin
          if (stuff_pending) begin
            emit = 1'b1;
          end else if (cnt_q != 4'd15) begin
            cnt_d    = cnt_nxt;
            emit     = 1'b1;
            emit_bit = ~crc[cnt_nxt];
          end else begin
            to_eop = 1'b1;
          end
        end
`endif
        ST_EOP_SE0: begin
          if (cnt_q == 4'(EOP_SE0_BITS - 1)) begin
            state_d = ST_EOP_J;
            line_d  = LINE_J;
          end else begin
            cnt_d  = cnt_nxt;
            line_d = LINE_SE0;
          end
        end
        ST_EOP_J: begin
          state_d = ST_IDLE;
          line_d  = LINE_J;
        end
        default: begin
          state_d = ST_IDLE;
          line_d  = LINE_J;
          ones_d  = '0;
        end
      endcase
    end

    if (emit) begin
      line_d = nrzi_next(line_q, emit_bit);
      ones_d = emit_bit ? ones_q + 1'b1 : '0;
    end
    if (to_eop) begin
      state_d = ST_EOP_SE0;
      cnt_d   = '0;
      line_d  = LINE_SE0;
      ones_d  = '0;
    end
  end

  // NOTE: non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      ones_q     <= '0;
      line_q     <= LINE_J;
      underrun_q <= 1'b0;
`ifdef USB_TX_CRC16_EN
      pid_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      ones_q     <= ones_d;
      line_q     <= line_d;
      underrun_q <= underrun_d;
`ifdef USB_TX_CRC16_EN
      pid_q      <= pid_d;
`endif
    end
  end

`ifdef USB_TX_CRC16_EN
  assign crc_clr = (state_q == ST_IDLE);

  usb_crc16 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (emit_bit),
    .crc_o (crc)
  );
`endif

  assign tx_busy            = (state_q != ST_IDLE);
  assign tx_underrun        = underrun_q;
  assign {d_plus, d_minus}  = line_q;

endmodule
